playseq_jogador_auto: RTL and testbench

Automatic player for the PlaySeq game. It watches the game's LED outputs during the preview phase and stores every LED shown into a small buffer. When the preview ends, it replays the stored sequence as timed button presses on the game's button inputs. The block sits between the PlaySeq datapath outputs (`leds`, `fase_preview`) and the button inputs, and is used for self-play on the board and for regression benches.

---
 rtl/playseq_auto_pkg.sv | 20 ++
 rtl/playseq_auto_buffer.sv | 23 ++
 rtl/playseq_jogador_auto.sv | 169 ++++++++++++++++
 tb/tb_playseq_jogador_auto.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/playseq_auto_pkg.sv
// rtl/playseq_auto_pkg.sv - shared state encoding and default sizing for the PlaySeq auto-player
package playseq_auto_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CAPTURA   = 2'd1,
    APERTA    = 2'd2,
    INTERVALO = 2'd3
  } estado_t;

  localparam int MAX_JOGADAS_PADRAO = 16;
  localparam int LARGURA_PADRAO     = 4;
  localparam int T_APERTO_PADRAO    = 5;
  localparam int T_INTERVALO_PADRAO = 3;

  function automatic int maior(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/playseq_auto_buffer.sv
// rtl/playseq_auto_buffer.sv - captured-LED register file, sync write, async read, no content reset
module playseq_auto_buffer #(
  parameter int MAX_JOGADAS = 16,
  parameter int LARGURA     = 4,
  localparam int AW         = $clog2(MAX_JOGADAS)
) (
  input  logic               clock,
  input  logic               we,
  input  logic [AW-1:0]      addr_w,
  input  logic [LARGURA-1:0] dado_w,
  input  logic [AW-1:0]      addr_r,
  output logic [LARGURA-1:0] dado_r
);

  logic [LARGURA-1:0] mem [MAX_JOGADAS];

  always_ff @(posedge clock) begin
    if (we) mem[addr_w] <= dado_w;
  end

  assign dado_r = mem[addr_r];

endmodule

// File: rtl/playseq_jogador_auto.sv
// rtl/playseq_jogador_auto.sv - PlaySeq auto-player: captures preview LEDs, replays them as presses (option: PLAYSEQ_AUTO_FALHA_EN)
module playseq_jogador_auto
  import playseq_auto_pkg::*;
#(
  parameter int MAX_JOGADAS = MAX_JOGADAS_PADRAO,
  parameter int LARGURA     = LARGURA_PADRAO,
  parameter int T_APERTO    = T_APERTO_PADRAO,
  parameter int T_INTERVALO = T_INTERVALO_PADRAO,
  localparam int CW         = $clog2(MAX_JOGADAS) + 1,
  localparam int IW         = $clog2(MAX_JOGADAS),
  localparam int TMAX       = maior(T_APERTO, T_INTERVALO),
  localparam int TW         = (TMAX > 1) ? $clog2(TMAX) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               habilita,
  input  logic               limpa,
  input  logic               fase_preview,
  input  logic [LARGURA-1:0] leds,
`ifdef PLAYSEQ_AUTO_FALHA_EN
  input  logic               injeta_falha,
`endif
  output logic [LARGURA-1:0] botoes,
  output logic               ocupado,
  output logic               erro_padrao,
  output logic               erro_cheio,
  output logic [CW-1:0]      db_contagem,
  output logic [1:0]         db_estado
);

  estado_t            estado;
  logic [CW-1:0]      count;
  logic [IW-1:0]      idx;
  logic [TW-1:0]      timer;
  logic [LARGURA-1:0] leds_q;
  logic               fase_preview_q;
  logic [LARGURA-1:0] dado_r;
`ifdef PLAYSEQ_AUTO_FALHA_EN
  logic               falha_q;
`endif

  logic subida, evento, cheio, ultimo, grava;

  assign subida = fase_preview & ~fase_preview_q;
  assign evento = (estado == CAPTURA) && (leds != '0) && (leds_q == '0);
  assign cheio  = (count == CW'(MAX_JOGADAS));
  assign ultimo = ({1'b0, idx} == (count - CW'(1)));
  // Write strobe must mirror exactly the branch of the FSM that accepts a capture
  assign grava  = reset && !limpa && habilita && fase_preview && evento
                  && $onehot(leds) && !cheio;

  playseq_auto_buffer #(
    .MAX_JOGADAS(MAX_JOGADAS),
    .LARGURA    (LARGURA)
  ) u_buffer (
    .clock (clock),
    .we    (grava),
    .addr_w(count[IW-1:0]),
    .dado_w(leds),
    .addr_r(idx),
    .dado_r(dado_r)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado         <= OCIOSO;
      count          <= '0;
      idx            <= '0;
      timer          <= '0;
      leds_q         <= '0;
      fase_preview_q <= 1'b0;
      erro_padrao    <= 1'b0;
      erro_cheio     <= 1'b0;
`ifdef PLAYSEQ_AUTO_FALHA_EN
      falha_q        <= 1'b0;
`endif
    end else begin
      fase_preview_q <= fase_preview;
      if (limpa) begin
        estado      <= OCIOSO;
        count       <= '0;
        idx         <= '0;
        timer       <= '0;
        leds_q      <= '0;
        erro_padrao <= 1'b0;
        erro_cheio  <= 1'b0;
`ifdef PLAYSEQ_AUTO_FALHA_EN
        falha_q     <= 1'b0;
`endif
      end else begin
        leds_q <= leds;
        if (!habilita) begin
          estado <= OCIOSO;
        end else begin
          case (estado)
            OCIOSO: begin
              if (subida) begin
                estado <= CAPTURA;
                count  <= '0;
              end
            end
            CAPTURA: begin
              if (!fase_preview) begin
                if (count != '0) begin
                  estado <= APERTA;
                  idx    <= '0;
                  timer  <= '0;
`ifdef PLAYSEQ_AUTO_FALHA_EN
                  falha_q <= injeta_falha;
`endif
                end else begin
                  estado <= OCIOSO;
                end
              end else if (evento) begin
                if (!$onehot(leds)) erro_padrao <= 1'b1;
                else if (cheio)     erro_cheio  <= 1'b1;
                else                count       <= count + CW'(1);
              end
            end
            APERTA: begin
              if (subida) begin
                estado <= CAPTURA;
                count  <= '0;
              end else if (timer == TW'(T_APERTO - 1)) begin
                estado <= INTERVALO;
                timer  <= '0;
              end else begin
                timer <= timer + TW'(1);
              end
            end
            INTERVALO: begin
              if (subida) begin
                estado <= CAPTURA;
                count  <= '0;
              end else if (timer == TW'(T_INTERVALO - 1)) begin
                timer <= '0;
                if (ultimo) begin
                  estado <= OCIOSO;
                end else begin
                  idx    <= idx + IW'(1);
                  estado <= APERTA;
                end
              end else begin
                timer <= timer + TW'(1);
              end
            end
            default: estado <= OCIOSO;
          endcase
        end
      end
    end
  end

  // Presses are a pure decode of state registers, so nothing leaks outside APERTA
  always_comb begin
    botoes = '0;
    if (estado == APERTA) begin
      botoes = dado_r;
`ifdef PLAYSEQ_AUTO_FALHA_EN
      if (falha_q && ultimo) botoes = {dado_r[LARGURA-2:0], dado_r[LARGURA-1]};
`endif
    end
  end

  assign ocupado     = (estado != OCIOSO);
  assign db_contagem = count;
  assign db_estado   = estado;

endmodule

// File: tb/tb_playseq_jogador_auto.sv
// tb/tb_playseq_jogador_auto.sv - self-checking bench for playseq_jogador_auto
module tb_playseq_jogador_auto;

  localparam int MAXJ = 16;
  localparam int TA   = 5;
  localparam int TI   = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       habilita = 1'b0;
  logic       limpa = 1'b0;
  logic       fase_preview = 1'b0;
  logic [3:0] leds = 4'b0;
`ifdef PLAYSEQ_AUTO_FALHA_EN
  logic       injeta_falha = 1'b0;
`endif
  logic [3:0] botoes;
  logic       ocupado, erro_padrao, erro_cheio;
  logic [4:0] db_contagem;
  logic [1:0] db_estado;

  playseq_jogador_auto #(
    .MAX_JOGADAS(MAXJ), .LARGURA(4), .T_APERTO(TA), .T_INTERVALO(TI)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .limpa       (limpa),
    .fase_preview(fase_preview),
    .leds        (leds),
`ifdef PLAYSEQ_AUTO_FALHA_EN
    .injeta_falha(injeta_falha),
`endif
    .botoes      (botoes),
    .ocupado     (ocupado),
    .erro_padrao (erro_padrao),
    .erro_cheio  (erro_cheio),
    .db_contagem (db_contagem),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       fase;
    logic [3:0] leds;
    logic [1:0] est;
    int         cnt;
    logic       ep;
    logic [3:0] bot;
  } vec_t;
  vec_t tab[11];

  logic [3:0] stim_q[$];
  logic [3:0] exp_q[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask

  // Reference: every 0->nonzero LED is one event; one-hot ones fill a queue up to MAXJ,
  // replay is TA cycles of the entry followed by TI idle cycles per entry.
  task automatic run_preview();
    logic ep, ec;
    exp_q.delete();
    ep = 1'b0;
    ec = 1'b0;
    foreach (stim_q[i]) begin
      if ($countones(stim_q[i]) == 1) begin
        if (exp_q.size() < MAXJ) exp_q.push_back(stim_q[i]);
        else ec = 1'b1;
      end else begin
        ep = 1'b1;
      end
    end
    limpa = 1'b1; tick(); limpa = 1'b0;
    fase_preview = 1'b1; leds = 4'b0; tick();
    foreach (stim_q[i]) begin
      leds = stim_q[i];
      repeat ($urandom_range(1, 3)) tick();
      leds = 4'b0;
      repeat ($urandom_range(1, 2)) tick();
    end
    chk("ocupado_captura", ocupado, 1);
    fase_preview = 1'b0;
    tick();
    foreach (exp_q[k]) begin
      for (int c = 0; c < TA; c++) begin chk("botoes_aperta", botoes, exp_q[k]); tick(); end
      for (int c = 0; c < TI; c++) begin chk("botoes_intervalo", botoes, 0); tick(); end
    end
    chk("fim_estado", db_estado, 0);
    chk("fim_ocupado", ocupado, 0);
    chk("fim_contagem", db_contagem, exp_q.size());
    chk("fim_erro_padrao", erro_padrao, ep);
    chk("fim_erro_cheio", erro_cheio, ec);
  endtask

  initial begin
    tab[0]  = '{1'b1, 4'b0000, 2'd1, 0, 1'b0, 4'b0000};
    tab[1]  = '{1'b1, 4'b1000, 2'd1, 1, 1'b0, 4'b0000};
    tab[2]  = '{1'b1, 4'b1000, 2'd1, 1, 1'b0, 4'b0000};
    tab[3]  = '{1'b1, 4'b1000, 2'd1, 1, 1'b0, 4'b0000};
    tab[4]  = '{1'b1, 4'b0000, 2'd1, 1, 1'b0, 4'b0000};
    tab[5]  = '{1'b1, 4'b1000, 2'd1, 2, 1'b0, 4'b0000};
    tab[6]  = '{1'b1, 4'b0000, 2'd1, 2, 1'b0, 4'b0000};
    tab[7]  = '{1'b1, 4'b0011, 2'd1, 2, 1'b1, 4'b0000};
    tab[8]  = '{1'b1, 4'b0000, 2'd1, 2, 1'b1, 4'b0000};
    tab[9]  = '{1'b0, 4'b0000, 2'd2, 2, 1'b1, 4'b1000};
    tab[10] = '{1'b0, 4'b0000, 2'd2, 2, 1'b1, 4'b1000};

    repeat (2) tick();
    chk("rst_botoes", botoes, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_estado", db_estado, 0);
    chk("rst_contagem", db_contagem, 0);
    chk("rst_erro_padrao", erro_padrao, 0);
    chk("rst_erro_cheio", erro_cheio, 0);
    reset = 1'b1; habilita = 1'b1; tick();

    foreach (tab[i]) begin
      fase_preview = tab[i].fase;
      leds = tab[i].leds;
      tick();
      chk("tab_estado", db_estado, tab[i].est);
      chk("tab_contagem", db_contagem, tab[i].cnt);
      chk("tab_erro_padrao", erro_padrao, tab[i].ep);
      chk("tab_botoes", botoes, tab[i].bot);
    end

    // Abort by a new preview during the second press
    repeat (3) tick();
    chk("p1_fim_aperta", db_estado, 2);
    tick();
    chk("p1_intervalo_estado", db_estado, 3);
    chk("p1_intervalo_botoes", botoes, 0);
    repeat (3) tick();
    chk("p2_estado", db_estado, 2);
    chk("p2_botoes", botoes, 4'b1000);
    fase_preview = 1'b1; tick();
    chk("abort_estado", db_estado, 1);
    chk("abort_contagem", db_contagem, 0);
    chk("abort_botoes", botoes, 0);

    // habilita dropped mid-replay
    leds = 4'b0010; tick(); leds = 4'b0; tick();
    fase_preview = 1'b0; tick();
    chk("hab_botoes_antes", botoes, 4'b0010);
    tick();
    habilita = 1'b0; tick();
    chk("hab_estado", db_estado, 0);
    chk("hab_botoes", botoes, 0);
    chk("hab_ocupado", ocupado, 0);
    chk("hab_contagem_retida", db_contagem, 1);
    habilita = 1'b1;

    // reset asserted mid-replay
    fase_preview = 1'b1; tick();
    chk("rec_estado", db_estado, 1);
    leds = 4'b0100; tick(); leds = 4'b0; tick();
    fase_preview = 1'b0; tick();
    chk("rst2_botoes_antes", botoes, 4'b0100);
    reset = 1'b0; tick();
    chk("rst2_botoes", botoes, 0);
    chk("rst2_ocupado", ocupado, 0);
    chk("rst2_estado", db_estado, 0);
    chk("rst2_contagem", db_contagem, 0);
    chk("rst2_erro_padrao", erro_padrao, 0);
    reset = 1'b1; tick();

    stim_q = '{4'b0001, 4'b0100, 4'b0010};
    run_preview();

    stim_q.delete();
    for (int i = 0; i < 17; i++) stim_q.push_back(4'b0001 << $urandom_range(0, 3));
    run_preview();

    for (int r = 0; r < 25; r++) begin
      stim_q.delete();
      for (int i = 0; i < int'($urandom_range(0, 20)); i++) begin
        if ($urandom_range(0, 7) == 0) stim_q.push_back(4'($urandom_range(1, 15)));
        else stim_q.push_back(4'b0001 << $urandom_range(0, 3));
      end
      run_preview();
    end

`ifdef PLAYSEQ_AUTO_FALHA_EN
    limpa = 1'b1; tick(); limpa = 1'b0;
    injeta_falha = 1'b1;
    fase_preview = 1'b1; tick();
    leds = 4'b0001; tick(); leds = 4'b0; tick();
    leds = 4'b1000; tick(); leds = 4'b0; tick();
    fase_preview = 1'b0; tick();
    injeta_falha = 1'b0;
    chk("falha_p1", botoes, 4'b0001);
    repeat (TA + TI) tick();
    chk("falha_p2", botoes, 4'b0001);
    repeat (TA + TI) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
